hazard_flush_ctrl: RTL and testbench

//  Produces the pipeline-control side of the squash interface: PCsrc (bubble

---
 rtl/mips_pkg.sv | 13 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_flush_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline control blocks
// Purpose: FSM state encoding for the squash sequencer and the $zero register index.
// Ports: none (package).
package mips_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts cycles where inc is high; holds at all-ones instead of wrapping.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high clear to zero
//   inc    in   1      count this cycle
//   count  out  CNT_W  current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - load-use stall and branch squash control for a 5-stage MIPS pipe
// Purpose: detects load-use hazards and taken branches/jumps, sequences a FLUSH_SLOTS-cycle
//          squash window, and keeps saturating stall/flush cycle counters.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   IDEXMemRead  in   1      instruction in EX is a load
//   IDEXRt       in   5      destination register of the load in EX
//   IFIDRs       in   5      rs of the instruction in ID
//   IFIDRt       in   5      rt of the instruction in ID
//   BrTaken      in   1      branch taken / jump, one-cycle pulse
//   PCWrite      out  1      PC may update
//   IFIDWrite    out  1      IF/ID register may load
//   PCsrc        out  1      zero the control word entering ID/EX
//   IFFlush      out  1      zero the instruction entering IF/ID
//   StallCnt     out  CNT_W  load-use stall cycles, saturating
//   FlushCnt     out  CNT_W  squash cycles, saturating
module hazard_flush_ctrl
    import mips_pkg::*;
#(
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXRt,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             BrTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             PCsrc,
    output logic             IFFlush,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int                SLOT_W      = $clog2(FLUSH_SLOTS + 1);
    localparam logic [SLOT_W-1:0] SLOT_RELOAD = SLOT_W'(FLUSH_SLOTS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SLOT_W-1:0] r_slot_left;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic              w_hazard;

    // $zero is never a real producer, so a load targeting it never stalls.
    assign w_hazard = IDEXMemRead && (IDEXRt != REG_ZERO) &&
                      ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_slot_left <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot_left <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot_left;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        PCsrc       = 1'b0;
        IFFlush     = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (BrTaken) begin
                        // Redirect wins over a concurrent load-use hazard: the
                        // dependent instruction is squashed anyway.
                        IFFlush = 1'b1;
                        PCsrc   = 1'b1;
                        if (FLUSH_SLOTS > 1) begin
                            w_state_nxt = ST_FLUSH;
                            w_slot_nxt  = SLOT_RELOAD;
                        end
                    end else if (w_hazard) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        PCsrc     = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    IFFlush = 1'b1;
                    PCsrc   = 1'b1;
                    if (BrTaken) begin
                        // A newer redirect restarts the window.
                        w_slot_nxt = SLOT_RELOAD;
                    end else if (r_slot_left <= SLOT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                        w_slot_nxt  = '0;
                    end else begin
                        w_slot_nxt = r_slot_left - SLOT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_slot_nxt  = '0;
                end
            endcase
        end
    end

    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = ~PCWrite;
    assign w_flush_inc = IFFlush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - directed self-checking bench for hazard_flush_ctrl
module tb_hazard_flush_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             IDEXMemRead;
    logic [4:0]       IDEXRt;
    logic [4:0]       IFIDRs;
    logic [4:0]       IFIDRt;
    logic             BrTaken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             PCsrc;
    logic             IFFlush;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    int errors = 0;
    int checks = 0;

    hazard_flush_ctrl #(.FLUSH_SLOTS(2), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .IDEXMemRead (IDEXMemRead),
        .IDEXRt      (IDEXRt),
        .IFIDRs      (IFIDRs),
        .IFIDRt      (IFIDRt),
        .BrTaken     (BrTaken),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .PCsrc       (PCsrc),
        .IFFlush     (IFFlush),
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all four control outputs at once: {PCWrite, IFIDWrite, PCsrc, IFFlush}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PCWrite, IFIDWrite, PCsrc, IFFlush}, {28'd0, exp});
    endtask

    task automatic idle();
        IDEXMemRead = 1'b0;
        IDEXRt      = 5'd0;
        IFIDRs      = 5'd0;
        IFIDRt      = 5'd0;
        BrTaken     = 1'b0;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt_ex,
                         input logic [4:0] rs_id, input logic [4:0] rt_id, input logic br);
        IDEXMemRead = mr;
        IDEXRt      = rt_ex;
        IFIDRs      = rs_id;
        IFIDRt      = rt_id;
        BrTaken     = br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // 1. reset for two cycles; outputs forced even with hazard/branch inputs
        reset = 1'b1;
        idle();
        sample();
        chk_ctl("reset_ctl_idle", 4'b1100);
        next_cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1);
        sample();
        chk_ctl("reset_ctl_forced", 4'b1100);
        next_cycle();
        reset = 1'b0;
        idle();
        sample();
        chk_ctl("post_reset_ctl", 4'b1100);
        chk("post_reset_stallcnt", 32'(StallCnt), 32'd0);
        chk("post_reset_flushcnt", 32'(FlushCnt), 32'd0);

        // 2. load-use hazard on rs
        next_cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0);
        sample();
        chk_ctl("stall_rs", 4'b0010);
        next_cycle();
        idle();
        sample();
        chk_ctl("after_stall_rs", 4'b1100);
        chk("stallcnt_1", 32'(StallCnt), 32'd1);

        // hazard on rt
        next_cycle();
        drive(1'b1, 5'd9, 5'd2, 5'd9, 1'b0);
        sample();
        chk_ctl("stall_rt", 4'b0010);
        // register mismatch: no stall
        next_cycle();
        drive(1'b1, 5'd9, 5'd8, 5'd3, 1'b0);
        sample();
        chk_ctl("no_stall_mismatch", 4'b1100);
        // not a load: no stall
        next_cycle();
        drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b0);
        sample();
        chk_ctl("no_stall_not_load", 4'b1100);

        // 3. $zero never stalls
        next_cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        sample();
        chk_ctl("no_stall_zero", 4'b1100);
        next_cycle();
        idle();
        sample();
        chk("stallcnt_zero_unchanged", 32'(StallCnt), 32'd2);

        // 4. branch pulse: two squash cycles; hazard ignored in FLUSH
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        sample();
        chk_ctl("br_cycle0", 4'b1111);
        next_cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        sample();
        chk_ctl("br_cycle1_hazard_ignored", 4'b1111);
        next_cycle();
        idle();
        sample();
        chk_ctl("br_done", 4'b1100);
        chk("flushcnt_2", 32'(FlushCnt), 32'd2);
        chk("stallcnt_flush_unchanged", 32'(StallCnt), 32'd2);

        // 5. branch with concurrent hazard, then second branch in FLUSH
        next_cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1);
        sample();
        chk_ctl("br_over_hazard", 4'b1111);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        sample();
        chk_ctl("br_in_flush", 4'b1111);
        next_cycle();
        idle();
        sample();
        chk_ctl("br_extended", 4'b1111);
        next_cycle();
        sample();
        chk_ctl("br_ext_done", 4'b1100);
        chk("flushcnt_5", 32'(FlushCnt), 32'd5);
        chk("stallcnt_br_hazard", 32'(StallCnt), 32'd2);

        // 6. reset during FLUSH abandons the window and clears counters
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        sample();
        chk_ctl("br_before_reset", 4'b1111);
        next_cycle();
        idle();
        reset = 1'b1;
        sample();
        chk_ctl("reset_in_flush", 4'b1100);
        chk("flushcnt_6", 32'(FlushCnt), 32'd6);
        next_cycle();
        reset = 1'b0;
        sample();
        chk_ctl("run_after_flush_reset", 4'b1100);
        chk("stallcnt_cleared", 32'(StallCnt), 32'd0);
        chk("flushcnt_cleared", 32'(FlushCnt), 32'd0);

        // Saturation: 16 consecutive stall cycles on a 4-bit counter
        next_cycle();
        drive(1'b1, 5'd31, 5'd31, 5'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            sample();
            if (i == 3) chk("stallcnt_mid", 32'(StallCnt), 32'd3);
            if (i == 15) begin
                chk_ctl("stall_held", 4'b0010);
                chk("stallcnt_at_max", 32'(StallCnt), 32'd15);
            end
            next_cycle();
        end
        idle();
        sample();
        chk("stallcnt_saturated", 32'(StallCnt), 32'd15);
        chk_ctl("idle_after_sat", 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
